// File: rtl/aes128_iter_core.sv
// aes128_iter_core: iterative AES-128 encryptor, UNROLL rounds per clock, on-the-fly key expansion
module aes128_iter_core #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] datain,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dataout,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [127:0] st_q, st_d, rk_q, rk_d, dout_q, dout_d, st_n, rk_n;
  logic [3:0] rnd_q, rnd_d;
  logic accept, fin;

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad
    $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xt(x);
    end
    return p;
  endfunction

  // GF(2^8) inverse as a^254 by square-and-multiply, then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s, r;
    s = gm(a, a);
    r = s;
    for (int i = 0; i < 6; i++) begin
      s = gm(s, s);
      r = gm(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 2; i <= 10; i++) rc = (4'(i) <= r) ? xt(rc) : rc;
    return rc;
  endfunction

  function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [3:0][7:0] a;
    logic [31:0] m;
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = sbox(s[127-8*(((c+r)%4)*4+r) -: 8]);
      m = {xt(a[0]) ^ xt(a[1]) ^ a[1] ^ a[2] ^ a[3],
           a[0] ^ xt(a[1]) ^ xt(a[2]) ^ a[2] ^ a[3],
           a[0] ^ a[1] ^ xt(a[2]) ^ xt(a[3]) ^ a[3],
           xt(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xt(a[3])};
      o[127-32*c -: 32] = (last ? {a[0], a[1], a[2], a[3]} : m) ^ k[127-32*c -: 32];
    end
    return o;
  endfunction

  for (genvar i = 0; i < UNROLL; i++) begin : g_rnd
    logic [127:0] st_i, rk_i, st_o, rk_o;
    logic [3:0] r;
    if (i == 0) begin : g_f
      assign st_i = st_q;
      assign rk_i = rk_q;
    end else begin : g_n
      assign st_i = g_rnd[i-1].st_o;
      assign rk_i = g_rnd[i-1].rk_o;
    end
    assign r    = rnd_q + 4'(i);
    assign rk_o = kexp(rk_i, rcon(r));
    assign st_o = aes_round(st_i, rk_o, r == 4'd10);
  end

  assign st_n = g_rnd[UNROLL-1].st_o;
  assign rk_n = g_rnd[UNROLL-1].rk_o;

  assign in_ready  = state_q == IDLE || (state_q == DONE && out_ready);
  assign out_valid = state_q == DONE;
  assign busy      = state_q == RUN;
  assign dataout   = dout_q;

  always_comb begin
    accept  = in_valid & in_ready;
    fin     = state_q == RUN && rnd_q + 4'(UNROLL - 1) == 4'd10;
    state_d = accept ? RUN : fin ? DONE : (state_q == DONE && out_ready) ? IDLE : state_q;
    st_d    = accept ? datain ^ key : state_q == RUN ? st_n : st_q;
    rk_d    = accept ? key : state_q == RUN ? rk_n : rk_q;
    rnd_d   = accept ? 4'd1 : state_q == RUN ? rnd_q + 4'(UNROLL) : rnd_q;
    dout_d  = fin ? st_n : dout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      rnd_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
      dout_q  <= dout_d;
    end
  end
endmodule
